multicycle_ctl: RTL and testbench
=================================

MULTICYCLE_CTL -- requirements
Module: multicycle_ctl

Interface
REQ-001 Parameter WAIT_W, default 4: width of the memory-wait counter; legal range 1..8; timeout fires at 2^WAIT_W-1 wait cycles.
REQ-002 Parameter ALU_OP_W, default 6: width of alu_op; fixed at 6 in this generation.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 opcode  in  7  instruction bits [6:0] from the datapath IR; stable from DECODE onward.
REQ-006 funct3  in  3  IR[14:12].
REQ-007 funct7  in  7  IR[31:25].
REQ-008 mem_ready  in  1  memory has completed the current request.
REQ-009 branch_taken  in  1  datapath compare result; valid in EXEC.
REQ-010 md_done  in  1  mul/div unit finished; used only with CTL_MULDIV_EN.
REQ-011 Strobe outputs, each 1 bit: mem_req, mem_we, ir_write, pc_write, reg_write, mem_read, mem_to_reg, alu_src, md_start.
REQ-012 i_format  out  6  one-hot format: bit0 R, bit1 I, bit2 S, bit3 B, bit4 U, bit5 J.
REQ-013 U_sel  out  2  00 none, 01 LUI, 10 AUIPC.
REQ-014 bj_type  out  3  000 none, 001 branch, 010 JAL, 011 JALR.
REQ-015 alu_op  out  6  [5:4] class (00 add, 01 arith, 10 compare, 11 pass-B), [3] funct7[5] (R-type and SRAI only), [2:0] funct3.
REQ-016 illegal  out  1  sticky trap flag.
REQ-017 state_dbg  out  3  current state encoding.

Function
REQ-018 The FSM SHALL be Moore with states IDLE, FETCH, DECODE, EXEC, MEM, WB, MULDIV, TRAP.
REQ-019 IDLE SHALL drive all outputs 0 and always go to FETCH on the next edge.
REQ-020 FETCH SHALL assert mem_req=1 and mem_we=0; when mem_ready=1 it SHALL pulse ir_write and pc_write (PC+4) and go to DECODE.
REQ-021 DECODE SHALL last exactly 1 cycle and go to EXEC; an unsupported opcode SHALL go to TRAP instead.
REQ-022 Supported opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
REQ-023 i_format, U_sel, bj_type, alu_op, alu_src and mem_to_reg SHALL be decoded from opcode/funct3/funct7 in DECODE through WB, and SHALL be 0 in IDLE, FETCH and TRAP.
REQ-024 EXEC for a branch SHALL assert pc_write iff branch_taken=1, then go to FETCH.
REQ-025 EXEC for JAL or JALR SHALL assert pc_write, then go to WB.
REQ-026 EXEC for a load or store SHALL go to MEM.
REQ-027 EXEC for all other supported opcodes SHALL go to WB.
REQ-028 MEM SHALL hold mem_req=1, with mem_we=1 for a store and mem_read=1 for a load; on mem_ready a load SHALL go to WB and a store SHALL go to FETCH.
REQ-029 WB SHALL pulse reg_write for exactly 1 cycle, then go to FETCH.
REQ-030 The wait counter SHALL clear on entry to FETCH or MEM and increment each cycle that mem_ready=0.
REQ-031 If the wait counter reaches 2^WAIT_W-1 with mem_ready still 0, the FSM SHALL go to TRAP.
REQ-032 mem_ready=1 on the saturating cycle SHALL win over the timeout.
REQ-033 TRAP SHALL hold illegal=1 and all strobes 0 until reset; all inputs SHALL be ignored.
REQ-034 mem_ready SHALL be ignored in every state other than FETCH and MEM.
REQ-035 Instruction latency SHALL be: R/I/U 4 cycles; branch 3; JAL/JALR 4; store 4; load 5; each count includes zero-wait memory and is extended by every memory wait cycle.

Reset
REQ-036 Asserting rst SHALL, asynchronously and in any state (including mid-MEM), force IDLE, clear the wait counter and illegal, and drive every output to 0.
REQ-037 After rst deasserts, the first mem_req SHALL appear in the second cycle (IDLE, then FETCH).

Configuration
REQ-038 With macro CTL_MULDIV_EN defined, opcode 0110011 with funct7=0000001 SHALL go from EXEC to MULDIV, pulsing md_start on entry.
REQ-039 With CTL_MULDIV_EN defined, MULDIV SHALL wait for md_done, then go to WB, and SHALL never time out.
REQ-040 Without CTL_MULDIV_EN, funct7=0000001 on opcode 0110011 SHALL be illegal and go to TRAP from DECODE; MULDIV SHALL be absent and md_start SHALL be tied to 0.

Structure
REQ-041 A shared package ctl_pkg SHALL hold the state enum, the opcode constants, and the i_format, U_sel, bj_type and alu_op class encodings.
REQ-042 A combinational sub-module ctl_decode SHALL map opcode/funct3/funct7 to the format and ALU fields; multicycle_ctl SHALL own the FSM and wait counter.

Verification
REQ-043 addi (0010011), mem_ready=1 every cycle -> states FETCH, DECODE, EXEC, WB; reg_write high in cycle 4 only; alu_op=01_0_000; i_format=000010.
REQ-044 lw with 3 wait cycles in MEM -> mem_req held 4 cycles in MEM, then WB with mem_to_reg=1; total latency 8 cycles.
REQ-045 beq with branch_taken=0, then beq with branch_taken=1 -> pc_write absent in the first EXEC, present in the second; each instruction takes 3 cycles.
REQ-046 WAIT_W=2, mem_ready held 0 in FETCH -> TRAP after 3 wait cycles with illegal=1; illegal stays 1 through 10 more cycles; rst then clears it.
REQ-047 Opcode 1111111 -> TRAP from DECODE; rst pulsed mid-MEM of a store -> mem_we drops in the same cycle, IDLE, then FETCH.
REQ-048 mul (funct7=0000001) -> with CTL_MULDIV_EN: md_start 1 cycle, wait for md_done after 5 cycles, then WB; without the macro: TRAP.

Source files
------------

// File: rtl/ctl_pkg.sv
// Shared types and encodings for the multicycle controller: state enum,
// opcode constants, format/U/branch-jump/ALU-class encodings and the decode bundle.
package ctl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_MULDIV = 3'd6,
    ST_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  localparam logic [5:0] FMT_NONE = 6'b000000;
  localparam logic [5:0] FMT_R    = 6'b000001;
  localparam logic [5:0] FMT_I    = 6'b000010;
  localparam logic [5:0] FMT_S    = 6'b000100;
  localparam logic [5:0] FMT_B    = 6'b001000;
  localparam logic [5:0] FMT_U    = 6'b010000;
  localparam logic [5:0] FMT_J    = 6'b100000;

  localparam logic [1:0] USEL_NONE  = 2'b00;
  localparam logic [1:0] USEL_LUI   = 2'b01;
  localparam logic [1:0] USEL_AUIPC = 2'b10;

  localparam logic [2:0] BJ_NONE   = 3'b000;
  localparam logic [2:0] BJ_BRANCH = 3'b001;
  localparam logic [2:0] BJ_JAL    = 3'b010;
  localparam logic [2:0] BJ_JALR   = 3'b011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_ARITH = 2'b01;
  localparam logic [1:0] ALU_CMP   = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  typedef struct packed {
    logic [5:0] fmt;
    logic [1:0] u_sel;
    logic [2:0] bj;
    logic [5:0] alu_op;
    logic       alu_src;
    logic       mem_to_reg;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jump;
    logic       is_muldiv;
    logic       legal;
  } dec_t;

  function automatic logic [5:0] alu_op_pack(input logic [1:0] cls, input logic f7b5,
                                             input logic [2:0] f3);
    return {cls, f7b5, f3};
  endfunction

endpackage

// File: rtl/ctl_decode.sv
// Combinational instruction decoder: opcode/funct3/funct7 to format, ALU and
// control-class fields. Macro CTL_MULDIV_EN makes funct7=0000001 on OP a mul/div.
module ctl_decode
  import ctl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dec_t       dec
);

  dec_t dec_raw_s;

  // Field decode; unsupported encodings leave legal low
  always_comb begin
    dec_raw_s       = '0;
    dec_raw_s.legal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_raw_s.fmt    = FMT_R;
        dec_raw_s.alu_op = alu_op_pack(ALU_ARITH, funct7[5], funct3);
`ifdef CTL_MULDIV_EN
        dec_raw_s.is_muldiv = (funct7 == F7_MULDIV);
`else
        dec_raw_s.legal = (funct7 != F7_MULDIV);
`endif
      end
      OPC_OP_IMM: begin
        // only SRAI/SRLI use funct7[5] among the immediate ops
        dec_raw_s.fmt     = FMT_I;
        dec_raw_s.alu_op  = alu_op_pack(ALU_ARITH, (funct3 == 3'b101) && funct7[5], funct3);
        dec_raw_s.alu_src = 1'b1;
      end
      OPC_LOAD: begin
        dec_raw_s.fmt        = FMT_I;
        dec_raw_s.alu_op     = alu_op_pack(ALU_ADD, 1'b0, funct3);
        dec_raw_s.alu_src    = 1'b1;
        dec_raw_s.mem_to_reg = 1'b1;
        dec_raw_s.is_load    = 1'b1;
      end
      OPC_STORE: begin
        dec_raw_s.fmt      = FMT_S;
        dec_raw_s.alu_op   = alu_op_pack(ALU_ADD, 1'b0, funct3);
        dec_raw_s.alu_src  = 1'b1;
        dec_raw_s.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        dec_raw_s.fmt       = FMT_B;
        dec_raw_s.bj        = BJ_BRANCH;
        dec_raw_s.alu_op    = alu_op_pack(ALU_CMP, 1'b0, funct3);
        dec_raw_s.is_branch = 1'b1;
      end
      OPC_JAL: begin
        dec_raw_s.fmt     = FMT_J;
        dec_raw_s.bj      = BJ_JAL;
        dec_raw_s.alu_op  = alu_op_pack(ALU_ADD, 1'b0, 3'b000);
        dec_raw_s.alu_src = 1'b1;
        dec_raw_s.is_jump = 1'b1;
      end
      OPC_JALR: begin
        dec_raw_s.fmt     = FMT_I;
        dec_raw_s.bj      = BJ_JALR;
        dec_raw_s.alu_op  = alu_op_pack(ALU_ADD, 1'b0, funct3);
        dec_raw_s.alu_src = 1'b1;
        dec_raw_s.is_jump = 1'b1;
      end
      OPC_LUI: begin
        dec_raw_s.fmt     = FMT_U;
        dec_raw_s.u_sel   = USEL_LUI;
        dec_raw_s.alu_op  = alu_op_pack(ALU_PASSB, 1'b0, 3'b000);
        dec_raw_s.alu_src = 1'b1;
      end
      OPC_AUIPC: begin
        dec_raw_s.fmt     = FMT_U;
        dec_raw_s.u_sel   = USEL_AUIPC;
        dec_raw_s.alu_op  = alu_op_pack(ALU_ADD, 1'b0, 3'b000);
        dec_raw_s.alu_src = 1'b1;
      end
      default: dec_raw_s.legal = 1'b0;
    endcase
  end

  assign dec = dec_raw_s.legal ? dec_raw_s : '0;

endmodule

// File: rtl/multicycle_ctl.sv
// Multicycle Moore control FSM with memory-wait timeout and sticky trap.
// Macro CTL_MULDIV_EN adds the MULDIV state and the md_start/md_done handshake.
module multicycle_ctl
  import ctl_pkg::*;
#(
  parameter int WAIT_W   = 4,
  parameter int ALU_OP_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                mem_ready,
  input  logic                branch_taken,
  input  logic                md_done,
  output logic                mem_req,
  output logic                mem_we,
  output logic                ir_write,
  output logic                pc_write,
  output logic                reg_write,
  output logic                mem_read,
  output logic                mem_to_reg,
  output logic                alu_src,
  output logic                md_start,
  output logic [5:0]          i_format,
  output logic [1:0]          U_sel,
  output logic [2:0]          bj_type,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal,
  output logic [2:0]          state_dbg
);

  // Timeout is taken on the last allowed wait cycle, i.e. when the count would saturate
  localparam int                WAIT_LAST   = (1 << WAIT_W) - 2;
  localparam logic [WAIT_W-1:0] WAIT_LAST_V = WAIT_W'(WAIT_LAST);
  localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [WAIT_W-1:0] wait_cnt_nxt_s;
  logic              illegal_r;
  logic              wait_last_s;
  logic              dec_on_s;
  logic              md_go_s;
  dec_t              dec_s;

  ctl_decode u_decode (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .dec    (dec_s)
  );

  assign wait_last_s = (wait_cnt_r == WAIT_LAST_V);

  // State register, wait counter and sticky trap flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= {WAIT_W{1'b0}};
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      illegal_r  <= (state_nxt_s == ST_TRAP);
    end
  end

  // Next state and strobes; the counter is zero unless a memory wait continues
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = {WAIT_W{1'b0}};
    md_go_s        = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    reg_write      = 1'b0;
    mem_read       = 1'b0;
    case (state_r)
      ST_IDLE: state_nxt_s = ST_FETCH;
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write    = 1'b1;
          pc_write    = 1'b1;
          state_nxt_s = ST_DECODE;
        end else if (wait_last_s) begin
          state_nxt_s = ST_TRAP;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
        end
      end
      ST_DECODE: state_nxt_s = dec_s.legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (dec_s.is_branch) begin
          pc_write    = branch_taken;
          state_nxt_s = ST_FETCH;
        end else if (dec_s.is_jump) begin
          pc_write    = 1'b1;
          state_nxt_s = ST_WB;
        end else if (dec_s.is_load || dec_s.is_store) begin
          state_nxt_s = ST_MEM;
`ifdef CTL_MULDIV_EN
        end else if (dec_s.is_muldiv) begin
          md_go_s     = 1'b1;
          state_nxt_s = ST_MULDIV;
`endif
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req  = 1'b1;
        mem_we   = dec_s.is_store;
        mem_read = dec_s.is_load;
        if (mem_ready) begin
          state_nxt_s = dec_s.is_load ? ST_WB : ST_FETCH;
        end else if (wait_last_s) begin
          state_nxt_s = ST_TRAP;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + WAIT_ONE;
        end
      end
      ST_WB: begin
        reg_write   = 1'b1;
        state_nxt_s = ST_FETCH;
      end
`ifdef CTL_MULDIV_EN
      ST_MULDIV: state_nxt_s = md_done ? ST_WB : ST_MULDIV;
`endif
      ST_TRAP: state_nxt_s = ST_TRAP;
      default: state_nxt_s = ST_TRAP;
    endcase
  end

`ifdef CTL_MULDIV_EN
  logic md_start_r;

  // md_start is high for the first MULDIV cycle only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      md_start_r <= 1'b0;
    end else begin
      md_start_r <= md_go_s;
    end
  end

  assign md_start = md_start_r;
  logic unused_muldiv;
  assign unused_muldiv = md_go_s;
`else
  assign md_start = 1'b0;
  logic unused_muldiv;
  assign unused_muldiv = md_done ^ md_go_s ^ dec_s.is_muldiv;
`endif

  assign dec_on_s   = state_r inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_MULDIV};
  assign i_format   = dec_on_s ? dec_s.fmt : FMT_NONE;
  assign U_sel      = dec_on_s ? dec_s.u_sel : USEL_NONE;
  assign bj_type    = dec_on_s ? dec_s.bj : BJ_NONE;
  assign alu_op     = dec_on_s ? dec_s.alu_op : 6'b000000;
  assign alu_src    = dec_on_s & dec_s.alu_src;
  assign mem_to_reg = dec_on_s & dec_s.mem_to_reg;
  assign illegal    = illegal_r;
  assign state_dbg  = state_r;

endmodule

// File: tb/tb_multicycle_ctl.sv
// Directed bench for multicycle_ctl: default instance plus a WAIT_W=2 instance
// for the fetch timeout. Expectations depend on CTL_MULDIV_EN.
module tb_multicycle_ctl;
  import ctl_pkg::*;

  logic clk = 1'b0;
  logic rst, rst2, mem_ready, mr2, branch_taken, md_done;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic mem_req, mem_we, ir_write, pc_write, reg_write, mem_read, mem_to_reg, alu_src, md_start, illegal;
  logic [5:0] i_format, alu_op;
  logic [1:0] U_sel;
  logic [2:0] bj_type, state_dbg;

  logic mem_req2, mem_we2, ir_write2, pc_write2, reg_write2, mem_read2, mem_to_reg2, alu_src2, md_start2, illegal2;
  logic [5:0] i_format2, alu_op2;
  logic [1:0] U_sel2;
  logic [2:0] bj_type2, state2;

  logic [9:0] strobes;
  assign strobes = {mem_req, mem_we, ir_write, pc_write, reg_write, mem_read, mem_to_reg, alu_src, md_start, illegal};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .branch_taken(branch_taken), .md_done(md_done),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .md_start(md_start), .i_format(i_format), .U_sel(U_sel), .bj_type(bj_type),
    .alu_op(alu_op), .illegal(illegal), .state_dbg(state_dbg)
  );

  multicycle_ctl #(.WAIT_W(2)) dut_w2 (
    .clk(clk), .rst(rst2), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mr2), .branch_taken(branch_taken), .md_done(md_done),
    .mem_req(mem_req2), .mem_we(mem_we2), .ir_write(ir_write2), .pc_write(pc_write2),
    .reg_write(reg_write2), .mem_read(mem_read2), .mem_to_reg(mem_to_reg2), .alu_src(alu_src2),
    .md_start(md_start2), .i_format(i_format2), .U_sel(U_sel2), .bj_type(bj_type2),
    .alu_op(alu_op2), .illegal(illegal2), .state_dbg(state2)
  );

  task automatic chk_ss(input string tag, input logic [2:0] st, input logic [9:0] strb);
    checks++;
    assert (state_dbg === st) else begin
      errors++;
      $error("FAIL %s state_dbg got %0d expected %0d", tag, state_dbg, st);
    end
    checks++;
    assert (strobes === strb) else begin
      errors++;
      $error("FAIL %s strobes got %b expected %b", tag, strobes, strb);
    end
  endtask

  task automatic chk_dec(input string tag, input logic [16:0] exp);
    checks++;
    assert ({i_format, U_sel, bj_type, alu_op} === exp) else begin
      errors++;
      $error("FAIL %s decode got %b expected %b", tag, {i_format, U_sel, bj_type, alu_op}, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic mr, input logic bt, input logic md,
                     input logic [2:0] st, input logic [9:0] strb);
    @(negedge clk);
    mem_ready = mr; branch_taken = bt; md_done = md;
    #1;
    chk_ss(tag, st, strb);
  endtask

  task automatic fetch(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    @(negedge clk);
    opcode = op; funct3 = f3; funct7 = f7;
    mem_ready = 1'b1; branch_taken = 1'b0; md_done = 1'b0;
    #1;
    chk_ss({tag, "_fetch"}, ST_FETCH, 10'b1011000000);
    chk_dec({tag, "_fetch"}, 17'b0);
  endtask

  task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [16:0] exp, input logic src);
    fetch(tag, op, f3, f7);
    cyc({tag, "_dec"}, 1'b0, 1'b0, 1'b0, ST_DECODE, {7'b0000000, src, 2'b00});
    chk_dec({tag, "_dec"}, exp);
    cyc({tag, "_exec"}, 1'b0, 1'b0, 1'b0, ST_EXEC, {7'b0000000, src, 2'b00});
    cyc({tag, "_wb"}, 1'b0, 1'b0, 1'b0, ST_WB, {4'b0000, 1'b1, 2'b00, src, 2'b00});
  endtask

  task automatic run_jump(input string tag, input logic [6:0] op, input logic [16:0] exp);
    fetch(tag, op, 3'b000, 7'b0000000);
    cyc({tag, "_dec"}, 1'b0, 1'b0, 1'b0, ST_DECODE, 10'b0000000100);
    chk_dec({tag, "_dec"}, exp);
    cyc({tag, "_exec"}, 1'b0, 1'b0, 1'b0, ST_EXEC, 10'b0001000100);
    cyc({tag, "_wb"}, 1'b0, 1'b0, 1'b0, ST_WB, 10'b0000100100);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; mem_ready = 1'b0; mr2 = 1'b0; branch_taken = 1'b0; md_done = 1'b0;
    opcode = 7'b0010011; funct3 = 3'b000; funct7 = 7'b0000000;

    // reset state, then WAIT_W=2 timeout on the second instance
    @(negedge clk); #1;
    chk_ss("reset", ST_IDLE, 10'b0);
    chk_dec("reset", 17'b0);
    @(negedge clk); rst2 = 1'b0; #1;
    chk2("w2_idle", {5'b0, state2}, {5'b0, ST_IDLE});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mr2 = 1'b0; #1;
      chk2("w2_wait", {4'b0, state2, mem_req2}, {4'b0, ST_FETCH, 1'b1});
    end
    @(negedge clk); #1;
    chk2("w2_trap", {3'b0, state2, illegal2, mem_req2}, {3'b0, ST_TRAP, 2'b10});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); mr2 = 1'b1; #1;
      chk2("w2_sticky", {4'b0, state2, illegal2}, {4'b0, ST_TRAP, 1'b1});
    end
    @(negedge clk); rst2 = 1'b1; #1;
    chk2("w2_rst", {4'b0, state2, illegal2}, {4'b0, ST_IDLE, 1'b0});
    @(negedge clk); rst2 = 1'b0; mr2 = 1'b0; #1;
    chk2("w2_idle2", {5'b0, state2}, {5'b0, ST_IDLE});
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); mr2 = 1'b0; #1;
      chk2("w2_wait2", {5'b0, state2}, {5'b0, ST_FETCH});
    end
    @(negedge clk); mr2 = 1'b1; #1;
    chk2("w2_ready_wins", {4'b0, state2, ir_write2}, {4'b0, ST_FETCH, 1'b1});
    @(negedge clk); #1;
    chk2("w2_decode", {5'b0, state2}, {5'b0, ST_DECODE});
    @(negedge clk); rst2 = 1'b1;

    // main instance: IDLE then FETCH after reset release
    rst = 1'b0; #1;
    chk_ss("idle", ST_IDLE, 10'b0);
    run_alu("addi", 7'b0010011, 3'b000, 7'b0000000, {6'b000010, 2'b00, 3'b000, 6'b010000}, 1'b1);
    run_alu("srai", 7'b0010011, 3'b101, 7'b0100000, {6'b000010, 2'b00, 3'b000, 6'b011101}, 1'b1);
    run_alu("sub", 7'b0110011, 3'b000, 7'b0100000, {6'b000001, 2'b00, 3'b000, 6'b011000}, 1'b0);
    run_alu("lui", 7'b0110111, 3'b011, 7'b0000000, {6'b010000, 2'b01, 3'b000, 6'b110000}, 1'b1);
    run_alu("auipc", 7'b0010111, 3'b000, 7'b0000000, {6'b010000, 2'b10, 3'b000, 6'b000000}, 1'b1);

    // lw with three memory wait cycles
    fetch("lw", 7'b0000011, 3'b010, 7'b0000000);
    cyc("lw_dec", 1'b0, 1'b0, 1'b0, ST_DECODE, 10'b0000001100);
    chk_dec("lw_dec", {6'b000010, 2'b00, 3'b000, 6'b000010});
    cyc("lw_exec", 1'b1, 1'b0, 1'b0, ST_EXEC, 10'b0000001100);
    for (int i = 0; i < 3; i++) cyc("lw_mem_wait", 1'b0, 1'b0, 1'b0, ST_MEM, 10'b1000011100);
    cyc("lw_mem_done", 1'b1, 1'b0, 1'b0, ST_MEM, 10'b1000011100);
    cyc("lw_wb", 1'b0, 1'b0, 1'b0, ST_WB, 10'b0000101100);

    // beq not taken, bne taken
    fetch("beq", 7'b1100011, 3'b000, 7'b0000000);
    cyc("beq_dec", 1'b0, 1'b0, 1'b0, ST_DECODE, 10'b0);
    chk_dec("beq_dec", {6'b001000, 2'b00, 3'b001, 6'b100000});
    cyc("beq_exec_nt", 1'b0, 1'b0, 1'b0, ST_EXEC, 10'b0);
    fetch("bne", 7'b1100011, 3'b001, 7'b0000000);
    cyc("bne_dec", 1'b0, 1'b1, 1'b0, ST_DECODE, 10'b0);
    chk_dec("bne_dec", {6'b001000, 2'b00, 3'b001, 6'b100001});
    cyc("bne_exec_t", 1'b0, 1'b1, 1'b0, ST_EXEC, 10'b0001000000);

    run_jump("jal", 7'b1101111, {6'b100000, 2'b00, 3'b010, 6'b000000});
    run_jump("jalr", 7'b1100111, {6'b000010, 2'b00, 3'b011, 6'b000000});

    // sw completes, then a second sw is reset mid-MEM
    fetch("sw", 7'b0100011, 3'b010, 7'b0000000);
    cyc("sw_dec", 1'b0, 1'b0, 1'b0, ST_DECODE, 10'b0000000100);
    chk_dec("sw_dec", {6'b000100, 2'b00, 3'b000, 6'b000010});
    cyc("sw_exec", 1'b0, 1'b0, 1'b0, ST_EXEC, 10'b0000000100);
    cyc("sw_mem", 1'b1, 1'b0, 1'b0, ST_MEM, 10'b1100000100);
    fetch("sw2", 7'b0100011, 3'b010, 7'b0000000);
    cyc("sw2_dec", 1'b0, 1'b0, 1'b0, ST_DECODE, 10'b0000000100);
    cyc("sw2_exec", 1'b0, 1'b0, 1'b0, ST_EXEC, 10'b0000000100);
    cyc("sw2_mem", 1'b0, 1'b0, 1'b0, ST_MEM, 10'b1100000100);
    cyc("sw2_mem2", 1'b0, 1'b0, 1'b0, ST_MEM, 10'b1100000100);
    #2 rst = 1'b1; #1;
    chk_ss("rst_mid_mem", ST_IDLE, 10'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk_ss("rst_idle", ST_IDLE, 10'b0);

    // unsupported opcode traps from DECODE and ignores inputs
    fetch("bad", 7'b1111111, 3'b000, 7'b0000000);
    cyc("bad_dec", 1'b0, 1'b0, 1'b0, ST_DECODE, 10'b0);
    chk_dec("bad_dec", 17'b0);
    for (int i = 0; i < 3; i++) cyc("bad_trap", 1'b1, 1'b1, 1'b1, ST_TRAP, 10'b0000000001);
    @(negedge clk); rst = 1'b1; #1;
    chk_ss("trap_rst", ST_IDLE, 10'b0);
    @(negedge clk); rst = 1'b0; #1;
    chk_ss("trap_rst_idle", ST_IDLE, 10'b0);

    // mul: MULDIV handshake when enabled, trap otherwise
    fetch("mul", 7'b0110011, 3'b000, 7'b0000001);
    cyc("mul_dec", 1'b0, 1'b0, 1'b0, ST_DECODE, 10'b0);
`ifdef CTL_MULDIV_EN
    chk_dec("mul_dec", {6'b000001, 2'b00, 3'b000, 6'b010000});
    cyc("mul_exec", 1'b0, 1'b0, 1'b0, ST_EXEC, 10'b0);
    cyc("mul_start", 1'b0, 1'b0, 1'b0, ST_MULDIV, 10'b0000000010);
    for (int i = 0; i < 3; i++) cyc("mul_wait", 1'b1, 1'b0, 1'b0, ST_MULDIV, 10'b0);
    cyc("mul_done", 1'b0, 1'b0, 1'b1, ST_MULDIV, 10'b0);
    cyc("mul_wb", 1'b0, 1'b0, 1'b0, ST_WB, 10'b0000100000);
    cyc("mul_next", 1'b0, 1'b0, 1'b0, ST_FETCH, 10'b1000000000);
`else
    chk_dec("mul_dec", 17'b0);
    for (int i = 0; i < 2; i++) cyc("mul_trap", 1'b0, 1'b0, 1'b0, ST_TRAP, 10'b0000000001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
